zmaps_dma: RTL and testbench
============================

Name: zmaps_dma

Overview:
- Sequencer that block-copies 16-bit words from system memory into an FPGA EAB file (CRAM or SFILE).
- Drives the DMA side of the z80 mapping mux: dma_data, dma_wraddr, dma_cram_we, dma_sfile_we.
- The mux gives DMA priority whenever either write enable is high, so this block also paces its writes to leave Z80 slots.
- Configured by the port/DMA register block with a start pulse; reports busy/done.

Parameters:
- SRC_AW, 21, source word-address width.
- WR_GAP, 1, idle cycles inserted after each FPRAM write before the next read request (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse: latch config and begin transfer
- abort  in  1  terminate current transfer
- tgt  in  1  0 = CRAM, 1 = SFILE
- fp_addr  in  8  first FPRAM word address
- len  in  8  word count; 0 means 256
- src_addr  in  SRC_AW  first source word address
- mem_req  out  1  read request, held until mem_rdy
- mem_addr  out  SRC_AW  read word address
- mem_rdy  in  1  read data valid this cycle; completes request
- mem_rdata  in  16  read data
- dma_data  out  16  word to FPRAM
- dma_wraddr  out  8  FPRAM word address
- dma_cram_we  out  1  CRAM write strobe
- dma_sfile_we  out  1  SFILE write strobe
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (sync, rst=1 at clk edge) values:
  - State IDLE.
  - mem_req, dma_cram_we, dma_sfile_we, busy, done = 0.
  - mem_addr, dma_data, dma_wraddr = 0.
  - Internal counters = 0.
  - Reset mid-transfer drops mem_req with no further write.
- State IDLE:
  - On start (abort=0): latch tgt, fp_addr into wa, src_addr into mem_addr, and len into a 9-bit remaining count (len=0 loads 256).
  - busy=1 and go to REQ.
- State REQ:
  - mem_req=1 with stable mem_addr.
  - On mem_rdy: register mem_rdata into dma_data, drive wa onto dma_wraddr, go to WR.
- State WR, exactly one cycle:
  - Assert dma_cram_we if tgt=0, else dma_sfile_we; never both.
  - Post-increment: wa += 1 (8-bit wrap, 0xFF -> 0x00); mem_addr += 1 (wrap mod 2^SRC_AW); remaining -= 1.
  - If remaining reaches 0: go to FIN.
  - Otherwise: go to GAP if WR_GAP > 0, else REQ.
- State GAP:
  - Count WR_GAP cycles with no strobe and no mem_req, then go to REQ.
- State FIN:
  - done=1 for one cycle, busy=0, then IDLE.
- Latency:
  - start at edge N -> mem_req high from cycle N+1.
  - mem_rdy at cycle M -> write strobe in cycle M+1.
  - Last strobe at cycle K -> done at cycle K+1.
- Write strobes are high only in WR.
- dma_data and dma_wraddr hold their values outside WR.
- start while busy: ignored.
- abort in any non-IDLE state:
  - Next cycle is IDLE with busy=0 and done=0.
  - No strobe in the cycle after abort; mem_req drops.
  - A mem_rdy arriving in IDLE is ignored.
  - Abort in WR: that write still completes (strobe is already registered high).
- start and abort in the same cycle in IDLE: abort wins, stays IDLE.
- mem_rdy outside REQ: ignored.
- dma_wraddr wrap within one transfer is legal (e.g. fp_addr 0xF0, len 0x20 writes 0xF0..0xFF then 0x00..0x0F).

Test Plan:
- Basic CRAM copy, WR_GAP=1:
  - Stimulus: start with tgt=0, fp_addr=0x10, len=3, src=0x100; mem_rdy 2 cycles after each req, data 0xA000+addr.
  - Required: dma_cram_we pulses at wraddr 0x10/0x11/0x12 with data 0xA100/0xA101/0xA102.
  - Required: one GAP cycle between writes; done one cycle after the 3rd strobe; dma_sfile_we never high.
- SFILE full block:
  - Stimulus: tgt=1, len=0, fp_addr=0x00, mem_rdy immediate.
  - Required: exactly 256 dma_sfile_we pulses, wraddr 0x00..0xFF, mem_addr ends at src+256, one done pulse.
- Wrap:
  - Stimulus: fp_addr=0xFE, len=4, src=2^21-2.
  - Required: wraddr 0xFE, 0xFF, 0x00, 0x01; mem_addr 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001.
- Abort during REQ:
  - Stimulus: abort with mem_req high and mem_rdy late; mem_rdy then arrives.
  - Required: mem_req low and busy low next cycle; no strobe; no done.
  - Then a new start runs normally.
- start ignored while busy:
  - Stimulus: second start mid-transfer with different fp_addr.
  - Required: original sequence unaffected.
  - Stimulus: start+abort together in IDLE.
  - Required: busy stays 0.
- Reset mid-WR:
  - Stimulus: rst asserted during the strobe cycle.
  - Required: next cycle all outputs at reset values; no further strobes.

Source files
------------

// File: rtl/zmaps_dma.sv
`default_nettype none
// ============================================================================
//  Module   : zmaps_dma
//  Purpose  : Block-copy sequencer moving 16-bit words from system memory
//             into an FPGA EAB file (CRAM or SFILE) through the DMA side of
//             the z80 mapping mux. Writes are paced so the Z80 keeps slots.
//  Revision : 1.0  initial release
// ============================================================================
module zmaps_dma #(
    parameter int SRC_AW = 21,
    parameter int WR_GAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              tgt,
    input  logic [7:0]        fp_addr,
    input  logic [7:0]        len,
    input  logic [SRC_AW-1:0] src_addr,
    output logic              mem_req,
    output logic [SRC_AW-1:0] mem_addr,
    input  logic              mem_rdy,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       dma_data,
    output logic [7:0]        dma_wraddr,
    output logic              dma_cram_we,
    output logic              dma_sfile_we,
    output logic              busy,
    output logic              done
);

    // Last value of the gap counter before returning to REQ (unused when WR_GAP=0)
    localparam logic [3:0] GAP_LAST = 4'((WR_GAP > 0) ? (WR_GAP - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WR   = 3'd2,
        S_GAP  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        tgt_q;
    logic [7:0]  wa;
    logic [8:0]  remaining;
    logic [3:0]  gap_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and state-decoded outputs; abort returns any active state to IDLE
    always_comb begin
        state_nxt    = state;
        mem_req      = 1'b0;
        dma_cram_we  = 1'b0;
        dma_sfile_we = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) state_nxt = S_REQ;
            end
            S_REQ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (abort)        state_nxt = S_IDLE;
                else if (mem_rdy) state_nxt = S_WR;
            end
            S_WR: begin
                // The strobe is already committed for this cycle, even under abort
                dma_cram_we  = ~tgt_q;
                dma_sfile_we = tgt_q;
                busy         = 1'b1;
                if (abort)                  state_nxt = S_IDLE;
                else if (remaining == 9'd1) state_nxt = S_FIN;
                else if (WR_GAP > 0)        state_nxt = S_GAP;
                else                        state_nxt = S_REQ;
            end
            S_GAP: begin
                busy = 1'b1;
                if (abort)                    state_nxt = S_IDLE;
                else if (gap_cnt == GAP_LAST) state_nxt = S_REQ;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: config latch, read-data capture, and post-write address/count update
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q      <= 1'b0;
            wa         <= 8'd0;
            remaining  <= 9'd0;
            gap_cnt    <= 4'd0;
            mem_addr   <= '0;
            dma_data   <= 16'd0;
            dma_wraddr <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        tgt_q     <= tgt;
                        wa        <= fp_addr;
                        mem_addr  <= src_addr;
                        remaining <= (len == 8'd0) ? 9'd256 : {1'b0, len};
                    end
                end
                S_REQ: begin
                    if (mem_rdy && !abort) begin
                        dma_data   <= mem_rdata;
                        dma_wraddr <= wa;
                    end
                end
                S_WR: begin
                    wa        <= wa + 8'd1;
                    mem_addr  <= mem_addr + SRC_AW'(1);
                    remaining <= remaining - 9'd1;
                    gap_cnt   <= 4'd0;
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zmaps_dma.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zmaps_dma
//  Purpose  : Directed self-checking bench for zmaps_dma (WR_GAP = 1)
//  Revision : 1.0  initial release
// ============================================================================
module tb_zmaps_dma;
    localparam int SRC_AW = 21;

    typedef struct {
        logic [7:0]        wraddr;
        logic [15:0]       data;
        logic [SRC_AW-1:0] addr;
        logic              tgt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              tgt = 1'b0;
    logic [7:0]        fp_addr = 8'd0;
    logic [7:0]        len = 8'd0;
    logic [SRC_AW-1:0] src_addr = '0;
    logic              mem_req;
    logic [SRC_AW-1:0] mem_addr;
    logic              mem_rdy;
    logic [15:0]       mem_rdata = 16'd0;
    logic [15:0]       dma_data;
    logic [7:0]        dma_wraddr;
    logic              dma_cram_we;
    logic              dma_sfile_we;
    logic              busy;
    logic              done;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rdy_delay = 1;
    logic rsp_rdy = 1'b0;
    logic man_rdy = 1'b0;
    int   ncram = 0, nsfile = 0, ndone = 0;
    int   nstrobe_t = 0, first_cyc = 0, last_cyc = 0;
    int   cyc_s;
    exp_t expq[$];

    assign mem_rdy = rsp_rdy | man_rdy;

    zmaps_dma #(.SRC_AW(SRC_AW), .WR_GAP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tgt(tgt),
        .fp_addr(fp_addr), .len(len), .src_addr(src_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy),
        .mem_rdata(mem_rdata), .dma_data(dma_data), .dma_wraddr(dma_wraddr),
        .dma_cram_we(dma_cram_we), .dma_sfile_we(dma_sfile_we),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: raise mem_rdy after rdy_delay cycles of mem_req, data = A000 + addr
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                wcnt++;
                if (wcnt >= rdy_delay) begin
                    rsp_rdy   = 1'b1;
                    mem_rdata = 16'hA000 + mem_addr[15:0];
                    wcnt      = 0;
                end else begin
                    rsp_rdy = 1'b0;
                end
            end else begin
                rsp_rdy = 1'b0;
                wcnt    = 0;
            end
        end
    end

    // Strobe/done monitor against the expected-write queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dma_cram_we || dma_sfile_we) begin
                checks++;
                if ((dma_cram_we & dma_sfile_we) !== 1'b0) begin
                    errors++;
                    $error("FAIL we_exclusive: observed %0h expected 0", dma_cram_we & dma_sfile_we);
                end
                if (dma_cram_we)  ncram++;
                if (dma_sfile_we) nsfile++;
                if (nstrobe_t == 0) first_cyc = cyc;
                nstrobe_t++;
                last_cyc = cyc;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $error("FAIL strobe_expected: observed empty queue expected entry");
                end
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    checks++;
                    if (dma_wraddr !== e.wraddr) begin
                        errors++;
                        $error("FAIL wraddr: observed %0h expected %0h", dma_wraddr, e.wraddr);
                    end
                    checks++;
                    if (dma_data !== e.data) begin
                        errors++;
                        $error("FAIL data: observed %0h expected %0h", dma_data, e.data);
                    end
                    checks++;
                    if (mem_addr !== e.addr) begin
                        errors++;
                        $error("FAIL mem_addr_at_wr: observed %0h expected %0h", mem_addr, e.addr);
                    end
                    checks++;
                    if (dma_sfile_we !== e.tgt) begin
                        errors++;
                        $error("FAIL sfile_we: observed %0h expected %0h", dma_sfile_we, e.tgt);
                    end
                end
            end
            if (done) begin
                ndone++;
                checks++;
                if (cyc !== last_cyc + 1) begin
                    errors++;
                    $error("FAIL done_after_last_strobe: observed %0d expected %0d", cyc, last_cyc + 1);
                end
            end
        end
    end

    // Queue the writes a transfer is required to produce
    task automatic expect_xfer(input logic t, input logic [7:0] fp, input logic [7:0] l,
                               input logic [SRC_AW-1:0] src);
        int n;
        exp_t e;
        n = (l == 8'd0) ? 256 : int'(l);
        for (int i = 0; i < n; i++) begin
            e.wraddr = fp + 8'(i);
            e.addr   = src + SRC_AW'(i);
            e.data   = 16'hA000 + e.addr[15:0];
            e.tgt    = t;
            expq.push_back(e);
        end
    endtask

    // Pulse start with the given config; returns positioned #1 after the start edge
    task automatic do_start(input logic t, input logic [7:0] fp, input logic [7:0] l,
                            input logic [SRC_AW-1:0] src);
        tgt = t; fp_addr = fp; len = l; src_addr = src; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc_s = cyc;
    endtask

    // Wait (bounded) until busy drops, then one extra cycle so done is observed
    task automatic wait_idle(input int max_cyc, input string tag);
        int k;
        k = 0;
        while (busy && k < max_cyc) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $error("FAIL %s: observed %0h expected 0", tag, busy);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int c0, s0, d0;
        // Reset
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $error("FAIL rst_mem_req: observed %0h expected 0", mem_req); end
        checks++; if (busy !== 1'b0) begin errors++; $error("FAIL rst_busy: observed %0h expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $error("FAIL rst_done: observed %0h expected 0", done); end
        checks++; if (dma_cram_we !== 1'b0) begin errors++; $error("FAIL rst_cram_we: observed %0h expected 0", dma_cram_we); end
        checks++; if (dma_sfile_we !== 1'b0) begin errors++; $error("FAIL rst_sfile_we: observed %0h expected 0", dma_sfile_we); end
        checks++; if (mem_addr !== 21'd0) begin errors++; $error("FAIL rst_mem_addr: observed %0h expected 0", mem_addr); end
        checks++; if (dma_data !== 16'd0) begin errors++; $error("FAIL rst_dma_data: observed %0h expected 0", dma_data); end
        checks++; if (dma_wraddr !== 8'd0) begin errors++; $error("FAIL rst_wraddr: observed %0h expected 0", dma_wraddr); end
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic CRAM copy, rdy 2 cycles after req
        rdy_delay = 2; nstrobe_t = 0; d0 = ndone; s0 = nsfile; c0 = ncram;
        expect_xfer(1'b0, 8'h10, 8'd3, 21'h100);
        do_start(1'b0, 8'h10, 8'd3, 21'h100);
        checks++; if (busy !== 1'b1) begin errors++; $error("FAIL t1_busy: observed %0h expected 1", busy); end
        checks++; if (mem_req !== 1'b1) begin errors++; $error("FAIL t1_mem_req: observed %0h expected 1", mem_req); end
        checks++; if (mem_addr !== 21'h100) begin errors++; $error("FAIL t1_mem_addr: observed %0h expected 100", mem_addr); end
        wait_idle(100, "t1_timeout");
        checks++; if (first_cyc !== cyc_s + 2) begin errors++; $error("FAIL t1_first_strobe_lat: observed %0d expected %0d", first_cyc, cyc_s + 2); end
        checks++; if (last_cyc - first_cyc !== 8) begin errors++; $error("FAIL t1_strobe_spacing: observed %0d expected 8", last_cyc - first_cyc); end
        checks++; if (ncram - c0 !== 3) begin errors++; $error("FAIL t1_cram_cnt: observed %0d expected 3", ncram - c0); end
        checks++; if (nsfile - s0 !== 0) begin errors++; $error("FAIL t1_sfile_cnt: observed %0d expected 0", nsfile - s0); end
        checks++; if (ndone - d0 !== 1) begin errors++; $error("FAIL t1_done_cnt: observed %0d expected 1", ndone - d0); end
        checks++; if (expq.size() !== 0) begin errors++; $error("FAIL t1_queue_empty: observed %0d expected 0", expq.size()); end
        checks++; if (dma_wraddr !== 8'h12) begin errors++; $error("FAIL t1_wraddr_hold: observed %0h expected 12", dma_wraddr); end
        checks++; if (dma_data !== 16'hA102) begin errors++; $error("FAIL t1_data_hold: observed %0h expected A102", dma_data); end

        // SFILE full 256-word block, immediate rdy
        rdy_delay = 1; nstrobe_t = 0; d0 = ndone; s0 = nsfile;
        expect_xfer(1'b1, 8'h00, 8'd0, 21'h1000);
        do_start(1'b1, 8'h00, 8'd0, 21'h1000);
        wait_idle(2000, "t2_timeout");
        checks++; if (nsfile - s0 !== 256) begin errors++; $error("FAIL t2_sfile_cnt: observed %0d expected 256", nsfile - s0); end
        checks++; if (mem_addr !== 21'h1100) begin errors++; $error("FAIL t2_mem_addr_end: observed %0h expected 1100", mem_addr); end
        checks++; if (ndone - d0 !== 1) begin errors++; $error("FAIL t2_done_cnt: observed %0d expected 1", ndone - d0); end
        checks++; if (expq.size() !== 0) begin errors++; $error("FAIL t2_queue_empty: observed %0d expected 0", expq.size()); end

        // Wraparound of both FPRAM and source addresses
        d0 = ndone;
        expect_xfer(1'b0, 8'hFE, 8'd4, 21'h1FFFFE);
        do_start(1'b0, 8'hFE, 8'd4, 21'h1FFFFE);
        wait_idle(100, "t3_timeout");
        checks++; if (mem_addr !== 21'h000002) begin errors++; $error("FAIL t3_mem_addr_end: observed %0h expected 2", mem_addr); end
        checks++; if (ndone - d0 !== 1) begin errors++; $error("FAIL t3_done_cnt: observed %0d expected 1", ndone - d0); end
        checks++; if (expq.size() !== 0) begin errors++; $error("FAIL t3_queue_empty: observed %0d expected 0", expq.size()); end

        // Abort during REQ with late rdy, then a stray rdy in IDLE
        rdy_delay = 20; d0 = ndone; c0 = ncram; s0 = nsfile;
        do_start(1'b0, 8'h30, 8'd2, 21'h300);
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $error("FAIL t4_req_before_abort: observed %0h expected 1", mem_req); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $error("FAIL t4_req_after_abort: observed %0h expected 0", mem_req); end
        checks++; if (busy !== 1'b0) begin errors++; $error("FAIL t4_busy_after_abort: observed %0h expected 0", busy); end
        man_rdy = 1'b1;
        @(posedge clk); #1;
        man_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if ((ncram - c0) + (nsfile - s0) !== 0) begin errors++; $error("FAIL t4_no_strobe: observed %0d expected 0", (ncram - c0) + (nsfile - s0)); end
        checks++; if (ndone - d0 !== 0) begin errors++; $error("FAIL t4_no_done: observed %0d expected 0", ndone - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $error("FAIL t4_still_idle: observed %0h expected 0", busy); end
        rdy_delay = 1; d0 = ndone;
        expect_xfer(1'b0, 8'h40, 8'd2, 21'h50);
        do_start(1'b0, 8'h40, 8'd2, 21'h50);
        wait_idle(100, "t4b_timeout");
        checks++; if (ndone - d0 !== 1) begin errors++; $error("FAIL t4b_done_cnt: observed %0d expected 1", ndone - d0); end
        checks++; if (expq.size() !== 0) begin errors++; $error("FAIL t4b_queue_empty: observed %0d expected 0", expq.size()); end

        // Second start while busy is ignored
        rdy_delay = 2; d0 = ndone; c0 = ncram;
        expect_xfer(1'b0, 8'h20, 8'd4, 21'h200);
        do_start(1'b0, 8'h20, 8'd4, 21'h200);
        repeat (3) @(posedge clk);
        #1;
        do_start(1'b1, 8'h99, 8'd1, 21'h999);
        wait_idle(100, "t5_timeout");
        checks++; if (ncram - c0 !== 4) begin errors++; $error("FAIL t5_cram_cnt: observed %0d expected 4", ncram - c0); end
        checks++; if (ndone - d0 !== 1) begin errors++; $error("FAIL t5_done_cnt: observed %0d expected 1", ndone - d0); end
        checks++; if (expq.size() !== 0) begin errors++; $error("FAIL t5_queue_empty: observed %0d expected 0", expq.size()); end
        checks++; if (mem_addr !== 21'h204) begin errors++; $error("FAIL t5_mem_addr_end: observed %0h expected 204", mem_addr); end

        // start and abort together in IDLE
        abort = 1'b1;
        do_start(1'b0, 8'h55, 8'd1, 21'h555);
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $error("FAIL t6_busy: observed %0h expected 0", busy); end
        checks++; if (mem_req !== 1'b0) begin errors++; $error("FAIL t6_mem_req: observed %0h expected 0", mem_req); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $error("FAIL t6_busy_later: observed %0h expected 0", busy); end

        // Reset asserted during the first strobe cycle
        rdy_delay = 1; c0 = ncram;
        expect_xfer(1'b0, 8'h60, 8'd4, 21'h600);
        do_start(1'b0, 8'h60, 8'd4, 21'h600);
        for (int k = 0; k < 20 && !dma_cram_we; k++) begin
            @(posedge clk); #1;
        end
        checks++; if (dma_cram_we !== 1'b1) begin errors++; $error("FAIL t7_in_wr: observed %0h expected 1", dma_cram_we); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $error("FAIL t7_mem_req: observed %0h expected 0", mem_req); end
        checks++; if (busy !== 1'b0) begin errors++; $error("FAIL t7_busy: observed %0h expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $error("FAIL t7_done: observed %0h expected 0", done); end
        checks++; if (dma_cram_we !== 1'b0) begin errors++; $error("FAIL t7_cram_we: observed %0h expected 0", dma_cram_we); end
        checks++; if (mem_addr !== 21'd0) begin errors++; $error("FAIL t7_mem_addr: observed %0h expected 0", mem_addr); end
        checks++; if (dma_data !== 16'd0) begin errors++; $error("FAIL t7_dma_data: observed %0h expected 0", dma_data); end
        checks++; if (dma_wraddr !== 8'd0) begin errors++; $error("FAIL t7_wraddr: observed %0h expected 0", dma_wraddr); end
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (ncram - c0 !== 1) begin errors++; $error("FAIL t7_one_strobe_only: observed %0d expected 1", ncram - c0); end
        checks++; if (expq.size() !== 3) begin errors++; $error("FAIL t7_queue_left: observed %0d expected 3", expq.size()); end
        expq.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: observed running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
